// File: rtl/key_debounce_pkg.sv
// Shared types and default timing constants for the pushbutton debouncer.
// The defaults assume a 50 MHz CLOCK_50: 20 ms debounce, 0.5 s repeat delay,
// 0.1 s repeat period.
package key_debounce_pkg;

    // Per-key channel state.
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_PRESS   = 2'b01,
        PRESSED      = 2'b10,
        WAIT_RELEASE = 2'b11
    } kd_state_t;

    localparam int DEF_NUM_KEYS        = 2;
    localparam int DEF_CNT_W           = 26;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, per-key FSM
// and registered level/press/release outputs.
// Optional auto-repeat on a held key is built when KEY_DEBOUNCE_REPEAT_EN is
// defined; otherwise exactly one press pulse is produced per accepted press.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | released and stable
// WAIT_PRESS   | sample reads pressed, counting towards acceptance
// PRESSED      | pressed and stable (repeat timer runs here when built)
// WAIT_RELEASE | sample reads released, counting towards acceptance
import key_debounce_pkg::*;

module key_debounce_ch #(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       key_sync;
    logic             s;
    kd_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, press_nxt, release_nxt;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_TC = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_TC = CNT_W'(REPEAT_PERIOD - 1);
    logic             rpt_phase, rpt_phase_nxt;
    logic [CNT_W-1:0] rpt_tc;
    // Terminal count for the current repeat phase (first delay, then period).
    assign rpt_tc = rpt_phase ? RP_TC : RD_TC;
`endif

    // Synchronise the raw active-low key; reset value reads as released.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) key_sync <= 2'b11;
        else          key_sync <= {key_sync[0], key};
    end

    assign s = ~key_sync[1];

    // State register, counter and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rpt_phase   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rpt_phase   <= rpt_phase_nxt;
`endif
        end
    end

    // Next state and counter; the counter is reused for the repeat timer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = WAIT_PRESS;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_TC) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = CNT_ONE;
                end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
                    cnt_nxt = (cnt == rpt_tc) ? '0 : cnt + CNT_ONE;
`else
                    cnt_nxt = '0;
`endif
                end
            end
            WAIT_RELEASE: begin
                if (s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DB_TC) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pulse, level and repeat-phase values loaded on the next edge.
    always_comb begin
        press_nxt   = (state == WAIT_PRESS) && s && (cnt == DB_TC);
        release_nxt = (state == WAIT_RELEASE) && !s && (cnt == DB_TC);
        level_nxt   = key_level;
        if (press_nxt)   level_nxt = 1'b1;
        if (release_nxt) level_nxt = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        rpt_phase_nxt = rpt_phase;
        if ((state == PRESSED) && s && (cnt == rpt_tc)) begin
            press_nxt     = 1'b1;
            rpt_phase_nxt = 1'b1;
        end
        if (release_nxt) rpt_phase_nxt = 1'b0;
`endif
    end

endmodule

// File: rtl/key_debounce.sv
// Debounced pushbutton front end: NUM_KEYS independent channels turning raw
// active-low keys into a clean active-high level plus one-cycle press and
// release pulses. Auto-repeat is added when KEY_DEBOUNCE_REPEAT_EN is defined.
import key_debounce_pkg::*;

module key_debounce #(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] KEY_LEVEL,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE
);

    // One self-contained channel per key.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .CLOCK_50    (CLOCK_50),
            .RESET_N     (RESET_N),
            .key         (KEY[i]),
            .key_level   (KEY_LEVEL[i]),
            .key_press   (KEY_PRESS[i]),
            .key_release (KEY_RELEASE[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios with literal expectations plus a
// randomized bouncy-key run, all checked every cycle against a run-length model.
module tb_key_debounce;

    localparam int NK = 2;
    localparam int D  = 8;
    localparam int CW = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N;
    logic [NK-1:0] KEY;
    logic [NK-1:0] KEY_LEVEL, KEY_PRESS, KEY_RELEASE;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .KEY         (KEY),
        .KEY_LEVEL   (KEY_LEVEL),
        .KEY_PRESS   (KEY_PRESS),
        .KEY_RELEASE (KEY_RELEASE)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Model: the sample seen at an edge is the raw key two edges back. The
    // accepted level flips once the sample has disagreed with it for D
    // consecutive edges. Repeats count held edges since the last press pulse.
    logic [NK-1:0] hist0, hist1;
    logic [NK-1:0] exp_level, exp_press, exp_release;
    int            run   [NK];
    int            rep   [NK];
    bit            phase [NK];

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hist0 = '1; hist1 = '1;
            exp_level = '0; exp_press = '0; exp_release = '0;
            for (int k = 0; k < NK; k++) begin
                run[k] = 0; rep[k] = 0; phase[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                bit smp;
                smp = ~hist1[k];
                exp_press[k]   = 1'b0;
                exp_release[k] = 1'b0;
                if (smp != exp_level[k]) begin
                    run[k]++;
                    if (run[k] == D) begin
                        exp_level[k] = smp;
                        run[k] = 0;
                        rep[k] = 0;
                        if (smp) exp_press[k] = 1'b1;
                        else begin
                            exp_release[k] = 1'b1;
                            phase[k] = 1'b0;
                        end
                    end
                end else begin
                    if (exp_level[k]) begin
                        if (run[k] > 0) rep[k] = 0;
                        else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
                            rep[k]++;
                            if (rep[k] == (phase[k] ? RP : RD)) begin
                                exp_press[k] = 1'b1;
                                rep[k] = 0;
                                phase[k] = 1'b1;
                            end
`endif
                        end
                    end
                    run[k] = 0;
                end
            end
            hist1 = hist0;
            hist0 = KEY;
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge CLOCK_50) begin
        if (!done) begin
            n_cmp += 4;
            if (KEY_LEVEL !== exp_level) begin
                n_bad++;
                $display("FAIL level t=%0t got=%b exp=%b", $time, KEY_LEVEL, exp_level);
            end
            if (KEY_PRESS !== exp_press) begin
                n_bad++;
                $display("FAIL press t=%0t got=%b exp=%b", $time, KEY_PRESS, exp_press);
            end
            if (KEY_RELEASE !== exp_release) begin
                n_bad++;
                $display("FAIL release t=%0t got=%b exp=%b", $time, KEY_RELEASE, exp_release);
            end
            if ((KEY_PRESS & KEY_RELEASE) !== '0) begin
                n_bad++;
                $display("FAIL press_and_release t=%0t press=%b release=%b", $time, KEY_PRESS, KEY_RELEASE);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic at_neg(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        bit saw;
        int pcnt;
        int mode_bouncy;
        RESET_N = 1'b0;
        KEY     = '1;
        at_neg(3);
        chk("reset_level",   32'(KEY_LEVEL),   32'h0);
        chk("reset_press",   32'(KEY_PRESS),   32'h0);
        chk("reset_release", 32'(KEY_RELEASE), 32'h0);
        RESET_N = 1'b1;
        at_neg(3);

        // Basic press/release on key 0.
        KEY[0] = 1'b0;
        edges(9);  chk("press0_early", 32'(KEY_PRESS), 32'h0);
        edges(1);  chk("press0_at10",  32'(KEY_PRESS), 32'h1);
                   chk("level0_set",   32'(KEY_LEVEL), 32'h1);
        edges(1);  chk("press0_width", 32'(KEY_PRESS[0]), 32'h0);
        edges(19);
        at_neg(1);
        KEY[0] = 1'b1;
        edges(9);  chk("rel0_early",  32'(KEY_RELEASE), 32'h0);
        edges(1);  chk("rel0_at10",   32'(KEY_RELEASE), 32'h1);
                   chk("level0_clr",  32'(KEY_LEVEL),   32'h0);
        edges(1);  chk("rel0_width",  32'(KEY_RELEASE), 32'h0);
        at_neg(5);

        // Bounce rejection on key 1, then a stable press.
        saw = 1'b0;
        for (int r = 0; r < 5; r++) begin
            KEY[1] = 1'b0;
            repeat (3) begin edges(1); saw |= KEY_PRESS[1] | KEY_LEVEL[1]; end
            at_neg(1);
            KEY[1] = 1'b1;
            repeat (2) begin edges(1); saw |= KEY_PRESS[1] | KEY_LEVEL[1]; end
            at_neg(1);
        end
        chk("bounce_no_event", 32'(saw), 32'h0);
        KEY[1] = 1'b0;
        edges(9);  chk("press1_early", 32'(KEY_PRESS), 32'h0);
        edges(1);  chk("press1_at10",  32'(KEY_PRESS), 32'h2);
        at_neg(1);
        KEY = '1;
        at_neg(15);

        // Simultaneous press on both keys.
        KEY = '0;
        edges(10); chk("simul_press",  32'(KEY_PRESS), 32'h3);
        edges(1);  chk("simul_once",   32'(KEY_PRESS), 32'h0);
        at_neg(1);
        KEY = '1;
        at_neg(15);

        // Reset during WAIT_PRESS, then re-acceptance with the key still held.
        KEY[0] = 1'b0;
        edges(5);
        at_neg(1);
        #2 RESET_N = 1'b0;
        #1 chk("rst_mid_outputs", 32'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE}), 32'h0);
        at_neg(3);
        RESET_N = 1'b1;
        edges(9);  chk("rst_press_early", 32'(KEY_PRESS), 32'h0);
        edges(1);  chk("rst_press_at10",  32'(KEY_PRESS), 32'h1);
        at_neg(3);

        // Release glitch while pressed.
        KEY[0] = 1'b1;
        at_neg(4);
        KEY[0] = 1'b0;
        saw = 1'b0;
        repeat (15) begin edges(1); saw |= KEY_RELEASE[0]; end
        chk("glitch_no_release", 32'(saw), 32'h0);
        chk("glitch_level",      32'(KEY_LEVEL[0]), 32'h1);
        at_neg(1);
        KEY = '1;
        at_neg(15);

        // Long hold: repeat pulses only when the feature is built.
        KEY[0] = 1'b0;
        pcnt = 0;
        repeat (60) begin edges(1); pcnt += int'(KEY_PRESS[0]); end
`ifdef KEY_DEBOUNCE_REPEAT_EN
        chk("hold_press_count", 32'(pcnt), 32'd8);
`else
        chk("hold_press_count", 32'(pcnt), 32'd1);
`endif
        at_neg(1);
        KEY = '1;
        at_neg(15);

        // Randomized run alternating calm and bouncy stretches.
        mode_bouncy = 0;
        for (int c = 0; c < 4000; c++) begin
            if ((c % 200) == 0) mode_bouncy = int'($urandom_range(0, 1));
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 99) < (mode_bouncy != 0 ? 25 : 2))
                    KEY[k] = ~KEY[k];
            end
            at_neg(1);
        end

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
